// File: rtl/bus_initiator.sv
// Single-beat memory-bus initiator: takes a core request, drives rd/wr/addr/wdata,
// checks the decoder's hit/did, waits for the device ack (bounded) and returns a response.
module bus_initiator #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 16,
  parameter logic [2:0]  DNONE   = 3'd7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_err,
  output logic [2:0]        resp_did,
  output logic              rd,
  output logic              wr,
  output logic [15:0]       addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              hit,
  input  logic [2:0]        did,
  input  logic              ack,
  input  logic [DATA_W-1:0] rdata
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISS    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [15:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic [1:0]          resp_err_q, resp_err_d;
  logic [2:0]          resp_did_q, resp_did_d;
  logic [TW-1:0]       timer_q, timer_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= '0;
      resp_did_q   <= DNONE;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      resp_did_q   <= resp_did_d;
      timer_q      <= timer_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    resp_did_d   = resp_did_q;
    timer_d      = timer_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_we ? req_wdata : '0;
          rd_d    = ~req_we;
          wr_d    = req_we;
          state_d = S_ADDR;
        end
      end
      // Decoder outputs are combinational from the registered bus, so they settle here.
      S_ADDR: begin
        if (!hit || did == DNONE) begin
          rd_d         = 1'b0;
          wr_d         = 1'b0;
          resp_err_d   = ERR_MISS;
          resp_did_d   = DNONE;
          resp_rdata_d = '0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          resp_did_d = did;
          timer_d    = '0;
          state_d    = S_WAIT;
        end
      end
      // ack is tested before the timer so a same-cycle ack beats the timeout.
      S_WAIT: begin
        if (ack) begin
          rd_d         = 1'b0;
          wr_d         = 1'b0;
          resp_rdata_d = rd_q ? rdata : '0;
          resp_err_d   = ERR_OK;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rd_d         = 1'b0;
          wr_d         = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = ERR_TIMEOUT;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rd         = rd_q;
  assign wr         = wr_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign resp_did   = resp_did_q;

endmodule
